// File: rtl/screen_pkg.sv
// Shared framebuffer geometry, fill FSM state encoding and pixel-to-word addressing.
package screen_pkg;

    localparam int SCREEN_W      = 512;
    localparam int SCREEN_H      = 256;
    localparam int WORDS_PER_ROW = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_FIN
    } fill_state_t;

    // Word holding pixel (x, y); the MSB of that word is the leftmost pixel.
    function automatic logic [12:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
        int unsigned a;
        a = (32'(y) % SCREEN_H) * WORDS_PER_ROW + 32'(x) / (SCREEN_W / WORDS_PER_ROW);
        return a[12:0];
    endfunction

endpackage

// File: rtl/screen_fill_mask.sv
// Pixel mask of one framebuffer word: left edge keeps bits (15-x0)..0,
// right edge keeps bits 15..(15-x1), a word that is both gets the AND.
module screen_fill_mask (
    input  logic [3:0]  x0_lo,
    input  logic [3:0]  x1_lo,
    input  logic        is_first,
    input  logic        is_last,
    output logic [15:0] mask
);

    logic [15:0] left_mask;
    logic [15:0] right_mask;

    assign left_mask  = is_first ? (16'hFFFF >> x0_lo) : 16'hFFFF;
    assign right_mask = is_last ? (16'hFFFF << (4'd15 - x1_lo)) : 16'hFFFF;
    assign mask       = left_mask & right_mask;

endmodule

// File: rtl/screen_rect_fill.sv
// Rectangle fill engine driving the framebuffer CPU port: full words written directly,
// edge words by read-modify-write. Optional XOR fill enabled by SCREEN_FILL_XOR_EN.
module screen_rect_fill
    import screen_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [8:0]        cmd_x0,
    input  logic [8:0]        cmd_x1,
    input  logic [7:0]        cmd_y0,
    input  logic [7:0]        cmd_y1,
    input  logic              cmd_color,
`ifdef SCREEN_FILL_XOR_EN
    input  logic              cmd_xor,
`endif
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy,
    output logic              done
);

    fill_state_t       state;
    logic [8:0]        x0_r, x1_r;
    logic [7:0]        y0_r, y1_r, row;
    logic [4:0]        col;
    logic              color_r;
    logic              xor_r;
    logic [DATA_W-1:0] mask_r, mask_nx, merged, fill_dat;
    logic              last_col, fin, full_nx;
    logic [4:0]        nx_col, tgt_col;
    logic [7:0]        nx_row, tgt_row;

`ifndef SCREEN_FILL_XOR_EN
    assign xor_r = 1'b0;
`endif

    // Next-word position is resolved combinationally so that WR can chain
    // straight into the next WR, including across a row change.
    assign last_col = (col == x1_r[8:4]);
    assign fin      = last_col && (row == y1_r);
    assign nx_col   = last_col ? x0_r[8:4] : col + 5'd1;
    assign nx_row   = last_col ? row + 8'd1 : row;
    assign tgt_col  = (state == ST_SETUP) ? x0_r[8:4] : nx_col;
    assign tgt_row  = (state == ST_SETUP) ? y0_r : nx_row;

    screen_fill_mask u_mask (
        .x0_lo   (x0_r[3:0]),
        .x1_lo   (x1_r[3:0]),
        .is_first(tgt_col == x0_r[8:4]),
        .is_last (tgt_col == x1_r[8:4]),
        .mask    (mask_nx)
    );

    assign full_nx  = (mask_nx == '1) && !xor_r;
    assign fill_dat = color_r ? '1 : '0;
    assign merged   = xor_r   ? (mem_out ^ mask_r) :
                      color_r ? (mem_out | mask_r) : (mem_out & ~mask_r);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            x0_r        <= '0;
            x1_r        <= '0;
            y0_r        <= '0;
            y1_r        <= '0;
            row         <= '0;
            col         <= '0;
            color_r     <= 1'b0;
`ifdef SCREEN_FILL_XOR_EN
            xor_r       <= 1'b0;
`endif
            mask_r      <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_load    <= 1'b0;
            mem_address <= '0;
            mem_in      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        x0_r      <= (cmd_x0 > cmd_x1) ? cmd_x1 : cmd_x0;
                        x1_r      <= (cmd_x0 > cmd_x1) ? cmd_x0 : cmd_x1;
                        y0_r      <= (cmd_y0 > cmd_y1) ? cmd_y1 : cmd_y0;
                        y1_r      <= (cmd_y0 > cmd_y1) ? cmd_y0 : cmd_y1;
                        color_r   <= cmd_color;
`ifdef SCREEN_FILL_XOR_EN
                        xor_r     <= cmd_xor;
`endif
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP, ST_WR: begin
                    if (state == ST_WR && fin) begin
                        mem_load <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_FIN;
                    end else begin
                        row         <= tgt_row;
                        col         <= tgt_col;
                        mask_r      <= mask_nx;
                        mem_address <= ADDR_W'(pix_addr({tgt_col, 4'b0000}, tgt_row));
                        if (full_nx) begin
                            mem_load <= 1'b1;
                            mem_in   <= fill_dat;
                            state    <= ST_WR;
                        end else begin
                            mem_load <= 1'b0;
                            state    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    mem_in   <= merged;
                    mem_load <= 1'b1;
                    state    <= ST_WR;
                end
                ST_FIN: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_rect_fill.sv
// Bench for screen_rect_fill: framebuffer RAM model plus a pixel-level reference
// model of each rectangle command (final image, write order, cycle costs).
module tb_screen_rect_fill;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x0 = '0, cmd_x1 = '0;
    logic [7:0]  cmd_y0 = '0, cmd_y1 = '0;
    logic        cmd_color = 1'b0;
`ifdef SCREEN_FILL_XOR_EN
    logic        cmd_xor = 1'b0;
`endif
    logic [12:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;
    logic        busy;
    logic        done;

    logic        pre_we = 1'b0;
    logic [12:0] pre_addr = '0;
    logic [15:0] pre_dat = '0;

    logic [15:0] fb [0:8191] = '{default: 16'h0000};
    logic [15:0] exp_fb [0:8191];
    int          exp_addr[$];
    int          exp_busy, exp_lat;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    screen_rect_fill dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_x1     (cmd_x1),
        .cmd_y0     (cmd_y0),
        .cmd_y1     (cmd_y1),
        .cmd_color  (cmd_color),
`ifdef SCREEN_FILL_XOR_EN
        .cmd_xor    (cmd_xor),
`endif
        .mem_address(mem_address),
        .mem_in     (mem_in),
        .mem_load   (mem_load),
        .mem_out    (mem_out),
        .busy       (busy),
        .done       (done)
    );

    // Framebuffer: synchronous write, registered read (data the cycle after the address).
    always @(posedge clk) begin
        if (pre_we)
            fb[pre_addr] <= pre_dat;
        else if (mem_load)
            fb[mem_address] <= mem_in;
        mem_out <= fb[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic poke(input int addr, input logic [15:0] dat);
        pre_addr     = 13'(addr);
        pre_dat      = dat;
        pre_we       = 1'b1;
        exp_fb[addr] = dat;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Pixel-level reference: walks the normalized rectangle pixel by pixel.
    task automatic model_cmd(input int ax0, input int ax1, input int ay0, input int ay1,
                             input bit color, input bit xr);
        int x0, x1, y0, y1, lo, hi, cost, b;
        x0 = (ax0 < ax1) ? ax0 : ax1;
        x1 = (ax0 < ax1) ? ax1 : ax0;
        y0 = (ay0 < ay1) ? ay0 : ay1;
        y1 = (ay0 < ay1) ? ay1 : ay0;
        exp_addr.delete();
        exp_busy = 1;
        exp_lat  = 0;
        for (int y = y0; y <= y1; y++) begin
            for (int w = x0 / 16; w <= x1 / 16; w++) begin
                lo = (x0 > w * 16) ? x0 : w * 16;
                hi = (x1 < w * 16 + 15) ? x1 : w * 16 + 15;
                cost = ((hi - lo + 1) == 16 && !xr) ? 1 : 3;
                exp_busy += cost;
                if (exp_lat == 0) exp_lat = (cost == 1) ? 2 : 4;
                exp_addr.push_back(y * 32 + w);
                for (int x = lo; x <= hi; x++) begin
                    b = 15 - (x % 16);
                    if (xr) exp_fb[y * 32 + w][b] = ~exp_fb[y * 32 + w][b];
                    else    exp_fb[y * 32 + w][b] = color;
                end
            end
        end
    endtask

    task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                           input bit color, input bit xr, input bit hold, input string tag);
        int got[$];
        int nbusy = 0, lat = 0, bad = 0, diffs = 0, amis = 0;
        bit prev_load = 1'b0, seen_done = 1'b0;
        model_cmd(x0, x1, y0, y1, color, xr);
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
        cmd_x0    = 9'(x0);
        cmd_x1    = 9'(x1);
        cmd_y0    = 8'(y0);
        cmd_y1    = 8'(y1);
        cmd_color = color;
`ifdef SCREEN_FILL_XOR_EN
        cmd_xor   = xr;
`endif
        cmd_valid = 1'b1;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        for (int k = 1; k <= 20000 && !seen_done; k++) begin
            if (cmd_ready) bad++;
            if (busy) nbusy++;
            if (mem_load) begin
                if (lat == 0) lat = k;
                got.push_back(int'(mem_address));
            end
            if (done) begin
                seen_done = 1'b1;
                if (!prev_load || busy) bad++;
                cmd_valid = 1'b0;
            end
            prev_load = mem_load;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        check({tag, "_first_write_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
        check({tag, "_write_count"}, 32'(got.size()), 32'(exp_addr.size()));
        for (int i = 0; i < got.size() && i < exp_addr.size(); i++)
            if (got[i] != exp_addr[i]) amis++;
        check({tag, "_write_order"}, 32'(amis), 32'd0);
        check({tag, "_protocol"}, 32'(bad), 32'd0);
        check({tag, "_ready_after"}, {29'd0, cmd_ready, busy, done}, 32'h4);
        for (int i = 0; i < 8192; i++)
            if (fb[i] !== exp_fb[i]) diffs++;
        check({tag, "_image"}, 32'(diffs), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_load"}, 32'(mem_load), 32'd0);
        check({tag, "_addr"}, 32'(mem_address), 32'd0);
        check({tag, "_din"}, 32'(mem_in), 32'd0);
    endtask

    initial begin
        int rx0, rx1, ry0, ry1;
        bit rc, rxr;
        for (int i = 0; i < 8192; i++) exp_fb[i] = 16'h0000;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        @(negedge clk);

        run_cmd(0, 511, 0, 0, 1'b1, 1'b0, 1'b0, "row0_full");

        poke(32, 16'h0000);
        run_cmd(3, 5, 1, 1, 1'b1, 1'b0, 1'b0, "x3to5");
        check("word32", 32'(fb[32]), 32'h1C00);

        poke(64, 16'hFFFF);
        run_cmd(7, 0, 2, 2, 1'b0, 1'b0, 1'b0, "swapped_clear");
        check("word64", 32'(fb[64]), 32'h00FF);

        run_cmd(511, 511, 255, 255, 1'b1, 1'b0, 1'b1, "corner_held_valid");
        check("word8191_bit0", 32'(fb[8191][0]), 32'd1);

`ifdef SCREEN_FILL_XOR_EN
        poke(0, 16'hA5A5);
        run_cmd(0, 15, 0, 0, 1'b1, 1'b1, 1'b0, "xor_word0");
        check("word0_xor", 32'(fb[0]), 32'h5A5A);
`endif

        for (int n = 0; n < 20; n++) begin
            rx0 = int'($urandom_range(0, 511));
            rx1 = int'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) rx1 = (rx0 / 16) * 16 + int'($urandom_range(0, 15));
            ry0 = int'($urandom_range(0, 255));
            ry1 = ry0 + int'($urandom_range(0, 5));
            if (ry1 > 255) ry1 = 255;
            rc  = 1'($urandom_range(0, 1));
            rxr = 1'b0;
`ifdef SCREEN_FILL_XOR_EN
            rxr = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 1) == 1)
                run_cmd(rx1, rx0, ry1, ry0, rc, rxr, 1'b0, $sformatf("rand%0d", n));
            else
                run_cmd(rx0, rx1, ry0, ry1, rc, rxr, 1'b0, $sformatf("rand%0d", n));
        end

        // Reset in the 5th cycle of a full-screen fill, then a full-screen clear.
        cmd_x0 = 9'd0; cmd_x1 = 9'd511; cmd_y0 = 8'd0; cmd_y1 = 8'd255; cmd_color = 1'b1;
`ifdef SCREEN_FILL_XOR_EN
        cmd_xor = 1'b0;
`endif
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midfill_reset");
        reset_n = 1'b1;
        run_cmd(0, 511, 0, 255, 1'b0, 1'b0, 1'b0, "full_screen_clear");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/screen_rect_fill.md
# screen_rect_fill

Hardware rectangle-fill engine for the 512×256 monochrome framebuffer. It is the writer that drives the framebuffer's CPU-side port (`address` / `in` / `load` / `out`), muxed in place of the CPU while busy. It accepts one rectangle command at a time and fills the region with set or cleared pixels:
- full 16-pixel words are written directly;
- partial edge words use read-modify-write.

## Interface
Parameters:
- `ADDR_W`, 13: framebuffer word-address width.
- `DATA_W`, 16: framebuffer word width, pixels per word.

Ports:
- `clk`  in  1  system clock; same clock as the framebuffer CPU port.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  engine can accept; high only in IDLE.
- `cmd_x0`, `cmd_x1`  in  9 each  inclusive column bounds, 0..511.
- `cmd_y0`, `cmd_y1`  in  8 each  inclusive row bounds, 0..255.
- `cmd_color`  in  1  1 = set pixels (black), 0 = clear.
- `cmd_xor`  in  1  invert pixels; present only with `SCREEN_FILL_XOR_EN`.
- `mem_address`  out  13  framebuffer word address.
- `mem_in`  out  16  write data.
- `mem_load`  out  1  write strobe.
- `mem_out`  in  16  framebuffer read data; valid the cycle after the address is presented with `mem_load`=0.
- `busy`  out  1  high from accept to completion.
- `done`  out  1  one-cycle pulse after the last write.

## Operation
- Pixel mapping:
  - word address = y*32 + x[8:4];
  - bit = 15 − x[3:0], so the MSB is the leftmost pixel on screen.
- Handshake: a command is accepted on a cycle where `cmd_valid && cmd_ready`. Fields are registered at that point, and later changes to the inputs are ignored.
- Normalization at accept: if x0>x1 the two are swapped; if y0>y1 the two are swapped. Every command therefore fills at least one pixel.
- Traversal: rows y0..y1 in ascending order; within a row, words x0[8:4]..x1[8:4] in ascending order.
- Word mask:
  - left edge word: bits (15−x0[3:0])..0;
  - right edge word: bits 15..(15−x1[3:0]);
  - interior words: 0xFFFF;
  - when the first and last word are the same, the mask is the AND of both edge masks.
- FSM states:
  - IDLE: `cmd_ready`=1; go to SETUP on accept.
  - SETUP: load the row/word counters and compute the mask.
  - Per word:
    - if the mask is 0xFFFF and the operation is not XOR, go to WR;
    - otherwise go to RD → WAIT → WR.
  - RD: present the address with `mem_load`=0.
  - WAIT: capture merged = color ? (mem_out | mask) : (mem_out & ~mask); for XOR, mem_out ^ mask.
  - WR: `mem_load`=1, present the address and data. Then advance to the next word, or the next row, or go to FIN.
  - FIN: pulse `done` and return to IDLE.
- Reset (`reset_n`=0 at any clock edge, including mid-fill):
  - the FSM returns to IDLE and the counters clear;
  - outputs go to `cmd_ready`=1, `busy`=0, `done`=0, `mem_load`=0, `mem_address`=0, `mem_in`=0;
  - a partially filled rectangle is left as is; no rollback.

## Timing
- Accept to first `mem_load`: 2 cycles (SETUP, then WR) for a full word; 4 cycles for an edge word.
- Full words are written one per cycle. Each RMW word takes 3 cycles.
- Row change costs no extra cycle; address arithmetic is pipelined in WR.
- `mem_load` is never high during RD or WAIT, and is high for exactly one cycle per word.
- `done` is asserted in the cycle after the final WR; `busy` falls in that same cycle; `cmd_ready` rises the cycle after that.
- A full-screen fill (x 0..511, y 0..255) takes exactly 8192 write cycles plus 2 cycles of overhead.

## Configuration
- `SCREEN_FILL_XOR_EN` defined:
  - the `cmd_xor` port exists;
  - `cmd_xor`=1 inverts the masked pixels and forces RMW for every word;
  - `cmd_color` is ignored when `cmd_xor`=1.
- Not defined: no `cmd_xor` port; only set/clear fills are supported, and full words never perform a read.

## Structure
- Shared package `screen_pkg`:
  - SCREEN_W=512, SCREEN_H=256, WORDS_PER_ROW=32;
  - the FSM state enum;
  - the pixel-to-address function.
- Sub-module `screen_fill_mask`: combinational; takes (x0[3:0], x1[3:0], is_first, is_last) and produces the 16-bit mask. It is instantiated once.

## Test plan
- x 0..511, y0=y1=0, color 1 → 32 writes to addresses 0..31 with data 0xFFFF on consecutive cycles; no reads; `done` after the last write.
- x 3..5, y=1, word 32 preloaded 0x0000, color 1 → RD, WAIT, then one write to address 32 with 0x1C00.
- x0=7, x1=0, y=2, word 64 preloaded 0xFFFF, color 0 → swapped to 0..7; address 64 becomes 0x00FF.
- Single pixel (511,255), color 1 → one RMW on address 8191 setting bit 0. A `cmd_valid` held high during the fill is not accepted until `cmd_ready` returns.
- Assert `reset_n`=0 in the 5th cycle of a full-screen fill → next cycle all outputs are at reset values. A new command is then accepted on the following cycle.
- With `SCREEN_FILL_XOR_EN`: x 0..15, y=0, `cmd_xor`=1, word 0 = 0xA5A5 → word 0 becomes 0x5A5A via RMW.
